// File: rtl/cam_pkg.sv
// Shared widths and enumerations for the CAM sequencer/arbiter.
package cam_pkg;

  localparam int CAM_DW    = 7;
  localparam int CAM_DEPTH = 16;
  localparam int CAM_IW    = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    SEARCH,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    REQ_WR,
    REQ_SR
  } req_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with any/multi flags over a match vector.
module cam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic [DEPTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             any,
  output logic             multi
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one assigned.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - DEPTH'(1)));

endmodule

// File: rtl/cam_ctrl.sv
// Sequencer and round-robin arbiter in front of a 16x7 CAM.
// Optional write deduplication is enabled with `define CAM_CTRL_DEDUP_EN.
//
// state  | meaning
// INIT   | CAM reset held low for two clocks after rst
// IDLE   | arbitrate write/search requesters
// WRITE  | cam_we pulse, advance write pointer and valid mask
// SEARCH | key on cam_content, CAM compares this cycle
// WAIT   | cam_found valid, capture masked result
// RESP   | hold result until rsp_ready
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DW    = CAM_DW,
  parameter int DEPTH = CAM_DEPTH,
  parameter int IW    = CAM_IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_dup,
  input  logic             sr_valid,
  output logic             sr_ready,
  input  logic [DW-1:0]    sr_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_multi,
  output logic [IW-1:0]    rsp_index,
  output logic [DEPTH-1:0] rsp_mask,
  output logic             cam_rst_n,
  output logic             cam_we,
  output logic [DW-1:0]    cam_content,
  input  logic [DEPTH-1:0] cam_found,
  output logic [IW:0]      occupancy
);

  state_t           state;
  req_t             rr_last;
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] valid_mask;
  logic             init_cnt;
  logic             grant_wr;
  logic             grant_sr;
  logic [DEPTH-1:0] masked;
  logic [IW-1:0]    enc_idx;
  logic             enc_any;
  logic             enc_multi;

`ifdef CAM_CTRL_DEDUP_EN
  logic             dedup_op;
`endif

  always_comb begin
    grant_wr = 1'b0;
    grant_sr = 1'b0;
    if (state == IDLE) begin
      if (wr_valid && sr_valid) begin
        if (rr_last == REQ_SR) grant_wr = 1'b1;
        else                   grant_sr = 1'b1;
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (sr_valid) begin
        grant_sr = 1'b1;
      end
    end
  end

  assign wr_ready = grant_wr;
  assign sr_ready = grant_sr;

  // Entries never written still hold the CAM's reset value and must not match.
  assign masked = cam_found & valid_mask;

  cam_prio_enc #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_prio_enc (
    .vec   (masked),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

`ifndef CAM_CTRL_DEDUP_EN
  assign wr_dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      rr_last     <= REQ_SR;
      wr_ptr      <= DEPTH'(1);
      valid_mask  <= '0;
      occupancy   <= '0;
      init_cnt    <= 1'b1;
      cam_rst_n   <= 1'b0;
      cam_we      <= 1'b0;
      cam_content <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_multi   <= 1'b0;
      rsp_index   <= '0;
      rsp_mask    <= '0;
`ifdef CAM_CTRL_DEDUP_EN
      dedup_op    <= 1'b0;
      wr_dup      <= 1'b0;
`endif
    end else begin
`ifdef CAM_CTRL_DEDUP_EN
      wr_dup <= 1'b0;
`endif
      case (state)
        INIT: begin
          cam_we      <= 1'b0;
          cam_content <= '0;
          if (init_cnt == 1'b0) begin
            cam_rst_n <= 1'b1;
            state     <= IDLE;
          end else begin
            init_cnt <= 1'b0;
          end
        end

        IDLE: begin
          if (grant_wr) begin
            cam_content <= wr_data;
            if (sr_valid) rr_last <= REQ_WR;
`ifdef CAM_CTRL_DEDUP_EN
            dedup_op <= 1'b1;
            state    <= SEARCH;
`else
            cam_we <= 1'b1;
            state  <= WRITE;
`endif
          end else if (grant_sr) begin
            cam_content <= sr_key;
            if (wr_valid) rr_last <= REQ_SR;
`ifdef CAM_CTRL_DEDUP_EN
            dedup_op <= 1'b0;
`endif
            state <= SEARCH;
          end
        end

        WRITE: begin
          cam_we      <= 1'b0;
          cam_content <= '0;
          valid_mask  <= valid_mask | wr_ptr;
          wr_ptr      <= {wr_ptr[DEPTH-2:0], wr_ptr[DEPTH-1]};
          if (occupancy != (IW+1)'(DEPTH)) occupancy <= occupancy + 1'b1;
          state       <= IDLE;
        end

        SEARCH: begin
          state <= WAIT;
        end

        WAIT: begin
`ifdef CAM_CTRL_DEDUP_EN
          if (dedup_op) begin
            if (enc_any) begin
              wr_dup      <= 1'b1;
              cam_content <= '0;
              state       <= IDLE;
            end else begin
              cam_we <= 1'b1;
              state  <= WRITE;
            end
          end else begin
`else
          begin
`endif
            rsp_mask    <= masked;
            rsp_hit     <= enc_any;
            rsp_multi   <= enc_multi;
            rsp_index   <= enc_idx;
            rsp_valid   <= 1'b1;
            cam_content <= '0;
            state       <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Sequencer and arbiter in front of the 16-entry, 7-bit content-addressable memory.
- Takes a write requester and a search requester, each with a valid/ready handshake. Grants them round-robin.
- Drives the CAM's we/content/rst_n pins and mirrors the CAM's internal one-hot write pointer.
- Masks matches against never-written entries and returns an encoded search result.

Parameters:
- DW, 7, key/data width; must equal the CAM content width.
- DEPTH, 16, CAM entries; must equal the CAM depth.
- IW, 4, index width, clog2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle
- wr_data  in  DW  key to store
- sr_valid  in  1  search request
- sr_ready  out  1  search accepted this cycle
- sr_key  in  DW  key to look up
- rsp_valid  out  1  search result valid
- rsp_ready  in  1  result consumer ready
- rsp_hit  out  1  at least one valid entry matched
- rsp_multi  out  1  more than one valid entry matched
- rsp_index  out  IW  lowest-numbered matching entry (0 if miss)
- rsp_mask  out  DEPTH  masked one-hot/multi-hot match vector
- cam_rst_n  out  1  CAM synchronous active-low reset
- cam_we  out  1  CAM write enable
- cam_content  out  DW  CAM content bus
- cam_found  in  DEPTH  CAM registered match vector
- occupancy  out  IW+1  number of valid entries, saturating at DEPTH

Behaviour:
- Reset values while rst=1:
  - state=INIT, cam_rst_n=0, cam_we=0, cam_content=0.
  - wr_ready=0, sr_ready=0, rsp_valid=0, rsp_* = 0.
  - wr_ptr=1 (one-hot), valid_mask=0, occupancy=0, rr_last=search.
- INIT: held for exactly 2 clocks after rst deasserts with cam_rst_n=0, so the CAM's synchronous reset samples low. Then go to IDLE with cam_rst_n=1.
- Reset mid-operation: async rst returns the block to INIT immediately. Any in-flight response is dropped. The CAM is re-reset by the INIT sequence.
- IDLE arbitration, evaluated each cycle:
  - Only wr_valid: grant write.
  - Only sr_valid: grant search.
  - Both: grant the opposite of rr_last, then update rr_last.
  - The grant raises the matching *_ready combinationally for that cycle. The request is captured on valid&ready.
- WRITE (1 cycle):
  - Drive cam_we=1 and cam_content=captured data.
  - Set valid_mask |= wr_ptr. Rotate wr_ptr left; 1<<(DEPTH-1) wraps to 1.
  - occupancy += 1 unless already DEPTH.
  - Return to IDLE.
  - After wrap, the oldest entry is overwritten; valid_mask stays all-ones.
- SEARCH (1 cycle): drive cam_we=0 and cam_content=key. Go to WAIT.
- WAIT (1 cycle):
  - Hold cam_content. cam_found now reflects the compare of the SEARCH cycle.
  - Capture rsp_mask = cam_found & valid_mask. Derive:
    - rsp_hit = |mask
    - rsp_multi = more than one bit set
    - rsp_index = priority encode, lowest index wins
  - Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_valid&rsp_ready. Then go to IDLE; rsp_valid drops the next cycle.
  - No new grants while in RESP.
- Latency: search accepted at cycle T gives rsp_valid at T+3. Write accepted at T gives cam_we at T+1, and the entry is searchable by a search accepted at T+2 or later.
- cam_content is 0 outside WRITE/SEARCH/WAIT.
- Key 0 matches reset-cleared entries inside the CAM. These are removed by valid_mask, so searching 0 on an empty CAM is a miss.

Optional Feature:
- Macro: CAM_CTRL_DEDUP_EN.
- Defined:
  - An accepted write first runs SEARCH→WAIT with its own data.
  - If the masked match is nonzero, skip WRITE: no cam_we, pointer and occupancy unchanged, and pulse output wr_dup for 1 cycle.
  - Otherwise perform WRITE.
  - Write latency becomes 3 cycles. The dedup phase produces no rsp_valid.
- Undefined: wr_dup is tied 0 and writes are single-cycle as above. The wr_dup port exists in both builds.

Decomposition:
- Package cam_pkg holds:
  - CAM_DW=7, CAM_DEPTH=16, CAM_IW=4
  - state enum {INIT, IDLE, WRITE, SEARCH, WAIT, RESP}
  - requester enum {REQ_WR, REQ_SR}
- One sub-module, cam_prio_enc: DEPTH-bit vector in, lowest-set index, any and multi out; purely combinational.

Test Plan:
- Release rst → cam_rst_n low for 2 clocks, then high. Search key 0 → rsp_hit=0, rsp_mask=0.
- Write 0x2A, 0x15, 0x2A, then search 0x2A → rsp_hit=1, rsp_multi=1, rsp_index=0, rsp_mask=0x0005, occupancy=3.
- Write 17 distinct keys 0x01..0x11, then search 0x01 → miss (overwritten by 0x11). Search 0x11 → hit, index 0. occupancy=16.
- wr_valid and sr_valid held together for 4 grants → grants alternate starting with write (rr_last=search at reset). Hold rsp_ready=0 for 5 cycles → rsp_* stable, no further grants.
- Assert rst during WAIT → rsp_valid stays 0, INIT resequences, occupancy=0, and a prior key now misses.
- With CAM_CTRL_DEDUP_EN: write 0x33 twice → second write gives wr_dup pulse, occupancy=1, no second cam_we.
